// File: rtl/mem_read_arbi_pkg.sv
// Shared DDR arbiter definitions: FSM encoding, default widths, burst timeout.
package mem_read_arbi_pkg;

    localparam int DDR_MEM_DATA_BITS = 256;
    localparam int DDR_ADDR_WIDTH    = 30;
    localparam int DDR_TIMEOUT       = 8000;
    localparam int DDR_LEN_BITS      = 8;
    localparam int DDR_TIMER_BITS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_BEGIN = 3'd2,
        ST_READ  = 3'd3,
        ST_END   = 3'd4
    } rd_arb_state_t;

    // A channel may only be granted when it asks and its burst has a length.
    function automatic logic burst_eligible(input logic req,
                                            input logic [DDR_LEN_BITS-1:0] len);
        return req && (len != '0);
    endfunction

endpackage

// File: rtl/mem_read_arbi_rr_grant2.sv
// Two-way round-robin grant. The grant is combinational from the eligible
// mask; last_grant only moves when the caller commits a grant, so it also
// names the owner of the burst in flight.
module mem_rr_grant2 (
    input  logic       ddr_clk_i,
    input  logic       ddr_rst_i,
    input  logic [1:0] req,
    input  logic       commit,
    output logic       grant_valid,
    output logic       grant_idx,
    output logic       last_grant
);

    // Pick the requester that was not served last when both are eligible.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
    end

    // Remember the committed winner; resets to channel 1 so channel 0 goes first.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            last_grant <= 1'b1;
        end else if (commit && grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/mem_read_arbi.sv
// Read-side DDR arbiter: grants one of two client burst reads onto the DDR
// read-command port, steers returned beats to the owner and closes each
// burst with a one-cycle finish pulse.
//
// Handshake: chX_rd_ddr_req is a level held by the client until its
// chX_rd_ddr_finish pulse; rd_ddr_req is held until the controller's first
// rd_ddr_data_valid. Data strobes carry no backpressure: every cycle with
// a valid strobe is one beat. Registers are zero-delay (no clock-to-Q term).
module mem_read_arbi
    import mem_read_arbi_pkg::*;
#(
    parameter int MEM_DATA_BITS = DDR_MEM_DATA_BITS,
    parameter int ADDR_WIDTH    = DDR_ADDR_WIDTH,
    parameter int TIMEOUT       = DDR_TIMEOUT
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_i,
    // channel 0
    input  logic                     ch0_rd_ddr_req,
    input  logic [DDR_LEN_BITS-1:0]  ch0_rd_ddr_len,
    input  logic [ADDR_WIDTH-1:0]    ch0_rd_ddr_addr,
    output logic                     ch0_rd_ddr_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch0_rd_ddr_data,
    output logic                     ch0_rd_ddr_finish,
    // channel 1
    input  logic                     ch1_rd_ddr_req,
    input  logic [DDR_LEN_BITS-1:0]  ch1_rd_ddr_len,
    input  logic [ADDR_WIDTH-1:0]    ch1_rd_ddr_addr,
    output logic                     ch1_rd_ddr_data_valid,
    output logic [MEM_DATA_BITS-1:0] ch1_rd_ddr_data,
    output logic                     ch1_rd_ddr_finish,
    // DDR read controller
    output logic                     rd_ddr_req,
    output logic [DDR_LEN_BITS-1:0]  rd_ddr_len,
    output logic [ADDR_WIDTH-1:0]    rd_ddr_addr,
    input  logic                     rd_ddr_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_ddr_data,
    input  logic                     rd_ddr_finish,
    output logic                     rd_timeout,
    // observability
    output rd_arb_state_t            dbg_state
);

    localparam logic [DDR_TIMER_BITS-1:0] TIMER_LIMIT = TIMEOUT[DDR_TIMER_BITS-1:0];

    rd_arb_state_t               state;
    rd_arb_state_t               state_nxt;
    logic [1:0]                  elig;
    logic                        grant_commit;
    logic                        grant_valid;
    logic                        grant_idx;
    logic                        owner;
    logic [DDR_TIMER_BITS-1:0]   cnt_timer;
    logic                        timeout_hit;
    logic [DDR_LEN_BITS-1:0]     beat_cnt;
    logic [MEM_DATA_BITS-1:0]    data_r;
    logic                        valid_r;
    logic                        finish_d0;
    logic                        finish_d1;
    logic                        beat_fwd;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign elig[0]      = burst_eligible(ch0_rd_ddr_req, ch0_rd_ddr_len);
    assign elig[1]      = burst_eligible(ch1_rd_ddr_req, ch1_rd_ddr_len);
    assign grant_commit = (state == ST_CHECK);

    mem_rr_grant2 u_rr_grant (
        .ddr_clk_i   (ddr_clk_i),
        .ddr_rst_i   (ddr_rst_i),
        .req         (elig),
        .commit      (grant_commit),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .last_grant  (owner)
    );

    // Timer runs only while a burst is owned; overflow past the limit aborts it.
    assign timeout_hit = (state != ST_IDLE) && (state != ST_CHECK) &&
                         (cnt_timer > TIMER_LIMIT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a timeout overrides whatever the burst was doing.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = ST_CHECK;
            ST_CHECK: if (grant_valid) state_nxt = ST_BEGIN;
            ST_BEGIN: state_nxt = ST_READ;
            ST_READ:  if (finish_d1) state_nxt = ST_END;
            ST_END:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Command side
    // ------------------------------------------------------------------
    // Latch the owner's command in BEGIN; drop the request on first data,
    // on abort, or when the burst closes without ever returning data.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            rd_ddr_req  <= 1'b0;
            rd_ddr_len  <= '0;
            rd_ddr_addr <= '0;
        end else if (timeout_hit) begin
            rd_ddr_req  <= 1'b0;
        end else if (state == ST_BEGIN) begin
            rd_ddr_req  <= 1'b1;
            rd_ddr_len  <= owner ? ch1_rd_ddr_len  : ch0_rd_ddr_len;
            rd_ddr_addr <= owner ? ch1_rd_ddr_addr : ch0_rd_ddr_addr;
        end else if (state == ST_END) begin
            rd_ddr_req  <= 1'b0;
        end else if ((state == ST_READ) && rd_ddr_data_valid) begin
            rd_ddr_req  <= 1'b0;
        end
    end

    // Burst timer: cleared while no burst is owned, counting otherwise.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            cnt_timer <= '0;
        end else if ((state == ST_IDLE) || (state == ST_CHECK)) begin
            cnt_timer <= '0;
        end else begin
            cnt_timer <= cnt_timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Data side
    // ------------------------------------------------------------------
    // One shared data register; only the valid strobe is steered per channel.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_ddr_data_valid;
            if (rd_ddr_data_valid) begin
                data_r <= rd_ddr_data;
            end
        end
    end

    // A registered beat is forwarded only while its burst still owes beats;
    // anything beyond the granted length is swallowed.
    assign beat_fwd = valid_r && (state == ST_READ) && (beat_cnt < rd_ddr_len);

    // Beat counter; saturates naturally at the burst length because extra
    // beats are never forwarded.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            beat_cnt <= '0;
        end else if (state == ST_BEGIN) begin
            beat_cnt <= '0;
        end else if (beat_fwd) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Controller finish delayed two cycles so it trails the one-cycle data path.
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            finish_d0 <= 1'b0;
            finish_d1 <= 1'b0;
        end else begin
            finish_d0 <= rd_ddr_finish && (state == ST_READ);
            finish_d1 <= finish_d0;
        end
    end

    // Channel-facing outputs steered by the burst owner.
    always_comb begin
        ch0_rd_ddr_data_valid = beat_fwd && !owner;
        ch1_rd_ddr_data_valid = beat_fwd &&  owner;
        ch0_rd_ddr_finish     = (state == ST_END) && !owner;
        ch1_rd_ddr_finish     = (state == ST_END) &&  owner;
        ch0_rd_ddr_data       = data_r;
        ch1_rd_ddr_data       = data_r;
        rd_timeout            = timeout_hit;
    end

endmodule

// File: tb/tb_mem_read_arbi.sv
module tb_mem_read_arbi;
  import mem_read_arbi_pkg::*;

  localparam int DW = 64;
  localparam int AW = 30;
  localparam int TO = 60;

  // ---------------- clock / reset ----------------
  logic ddr_clk_i = 1'b0;
  logic ddr_rst_i = 1'b1;
  always #5 ddr_clk_i = ~ddr_clk_i;

  int cyc = 0;
  always @(posedge ddr_clk_i) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          ch_req  [2];
  logic [7:0]    ch_len  [2];
  logic [AW-1:0] ch_addr [2];
  logic          ch0_valid, ch1_valid, ch0_fin, ch1_fin;
  logic [DW-1:0] ch0_data, ch1_data;
  logic          rd_ddr_req;
  logic [7:0]    rd_ddr_len;
  logic [AW-1:0] rd_ddr_addr;
  logic          rd_ddr_data_valid = 1'b0;
  logic [DW-1:0] rd_ddr_data = '0;
  logic          rd_ddr_finish = 1'b0;
  logic          rd_timeout;
  rd_arb_state_t dbg_state;

  mem_read_arbi #(.MEM_DATA_BITS(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .ddr_clk_i             (ddr_clk_i),
    .ddr_rst_i             (ddr_rst_i),
    .ch0_rd_ddr_req        (ch_req[0]),
    .ch0_rd_ddr_len        (ch_len[0]),
    .ch0_rd_ddr_addr       (ch_addr[0]),
    .ch0_rd_ddr_data_valid (ch0_valid),
    .ch0_rd_ddr_data       (ch0_data),
    .ch0_rd_ddr_finish     (ch0_fin),
    .ch1_rd_ddr_req        (ch_req[1]),
    .ch1_rd_ddr_len        (ch_len[1]),
    .ch1_rd_ddr_addr       (ch_addr[1]),
    .ch1_rd_ddr_data_valid (ch1_valid),
    .ch1_rd_ddr_data       (ch1_data),
    .ch1_rd_ddr_finish     (ch1_fin),
    .rd_ddr_req            (rd_ddr_req),
    .rd_ddr_len            (rd_ddr_len),
    .rd_ddr_addr           (rd_ddr_addr),
    .rd_ddr_data_valid     (rd_ddr_data_valid),
    .rd_ddr_data           (rd_ddr_data),
    .rd_ddr_finish         (rd_ddr_finish),
    .rd_timeout            (rd_timeout),
    .dbg_state             (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int model_last = 1;

  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] drv_q[$];
  int            drv_cyc_q[$];
  logic [DW-1:0] obs_q[$];
  int            obs_ch_q[$];
  int            obs_cyc_q[$];
  int            fin_cnt [2] = '{0, 0};
  int            fin_beats = 0;
  int            to_cnt = 0;
  int            req_hi_cnt = 0;
  int            req_rise_cnt = 0;
  int            req_rise_cyc = 0;
  logic          req_prev = 1'b0;

  // Passive monitor of everything the DUT shows the clients.
  always @(negedge ddr_clk_i) begin
    if (ch0_valid === 1'b1) begin obs_q.push_back(ch0_data); obs_ch_q.push_back(0); obs_cyc_q.push_back(cyc); end
    if (ch1_valid === 1'b1) begin obs_q.push_back(ch1_data); obs_ch_q.push_back(1); obs_cyc_q.push_back(cyc); end
    if (ch0_fin === 1'b1) begin fin_cnt[0]++; fin_beats = obs_q.size(); end
    if (ch1_fin === 1'b1) begin fin_cnt[1]++; fin_beats = obs_q.size(); end
    if (rd_timeout === 1'b1) to_cnt++;
    if (rd_ddr_req === 1'b1) req_hi_cnt++;
    if (rd_ddr_req === 1'b1 && req_prev !== 1'b1) begin req_rise_cnt++; req_rise_cyc = cyc; end
    req_prev = rd_ddr_req;
  end

  // Reference arbitration: eligible = req && len!=0; both -> the one not served last.
  function automatic int model_pick();
    bit e0, e1;
    e0 = (ch_req[0] === 1'b1) && (ch_len[0] != 0);
    e1 = (ch_req[1] === 1'b1) && (ch_len[1] != 0);
    if (e0 && e1) return (model_last == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    ddr_rst_i = 1'b1;
    repeat (2) @(negedge ddr_clk_i);
    ddr_rst_i = 1'b0;
    model_last = 1;
  endtask

  task automatic set_ch(input int c, input logic r, input logic [7:0] l, input logic [AW-1:0] a);
    ch_req[c] = r; ch_len[c] = l; ch_addr[c] = a;
  endtask

  // Controller model: wait for the command, return nbeats beats, optionally finish.
  task automatic serve_burst(input int ch, input int nbeats, input bit give_fin, input bit drop,
                             input bit gaps, output bit seen, output logic [AW-1:0] g_addr,
                             output logic [7:0] g_len);
    int waited;
    logic [DW-1:0] d;
    waited = 0; seen = 0; g_addr = '0; g_len = '0;
    while (rd_ddr_req !== 1'b1 && waited < 200) begin @(negedge ddr_clk_i); waited++; end
    if (rd_ddr_req !== 1'b1) return;
    seen = 1; g_addr = rd_ddr_addr; g_len = rd_ddr_len;
    if (drop) set_ch(ch, 1'b0, 8'($urandom_range(0, 255)), AW'($urandom));
    for (int b = 0; b < nbeats; b++) begin
      d = {$urandom, $urandom};
      rd_ddr_data_valid = 1'b1; rd_ddr_data = d;
      drv_q.push_back(d); drv_cyc_q.push_back(cyc);
      @(negedge ddr_clk_i);
      rd_ddr_data_valid = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) @(negedge ddr_clk_i);
    end
    if (give_fin) begin
      rd_ddr_finish = 1'b1;
      @(negedge ddr_clk_i);
      rd_ddr_finish = 1'b0;
    end
  endtask

  // One complete burst checked against the scoreboard.
  task automatic check_burst(input int exp_ch, input int nbeats, input bit drop, input bit gaps);
    logic [AW-1:0] e_addr, g_addr;
    logic [7:0]    e_len, g_len;
    int n_fwd, f_own, f_oth, waited;
    bit seen;
    e_addr = ch_addr[exp_ch]; e_len = ch_len[exp_ch];
    n_fwd  = (nbeats < int'(e_len)) ? nbeats : int'(e_len);
    f_own  = fin_cnt[exp_ch]; f_oth = fin_cnt[1 - exp_ch];
    model_last = exp_ch;
    exp_q.delete(); exp_cyc_q.delete(); drv_q.delete(); drv_cyc_q.delete();
    obs_q.delete(); obs_ch_q.delete(); obs_cyc_q.delete();
    serve_burst(exp_ch, nbeats, 1'b1, drop, gaps, seen, g_addr, g_len);
    checks++;
    if (!seen) begin errors++; $display("FAIL grant_seen: no rd_ddr_req for ch%0d", exp_ch); end
    checks++;
    if (g_addr !== e_addr) begin errors++; $display("FAIL cmd_addr: got %0h want %0h", g_addr, e_addr); end
    checks++;
    if (g_len !== e_len) begin errors++; $display("FAIL cmd_len: got %0d want %0d", g_len, e_len); end
    if (seen) for (int b = 0; b < n_fwd; b++) begin
      exp_q.push_back(drv_q[b]); exp_cyc_q.push_back(drv_cyc_q[b] + 1);
    end
    waited = 0;
    while (((exp_ch == 0) ? ch0_fin : ch1_fin) !== 1'b1 && waited < 20) begin
      @(negedge ddr_clk_i); waited++;
    end
    checks++;
    if (waited >= 20) begin errors++; $display("FAIL finish_seen: ch%0d finish missing", exp_ch); end
    @(negedge ddr_clk_i);
    checks++;
    if (fin_cnt[exp_ch] !== f_own + 1) begin
      errors++; $display("FAIL finish_count: got %0d want %0d", fin_cnt[exp_ch] - f_own, 1);
    end
    checks++;
    if (fin_cnt[1 - exp_ch] !== f_oth) begin
      errors++; $display("FAIL finish_other: got %0d want 0", fin_cnt[1 - exp_ch] - f_oth);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL beat_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int b = 0; b < exp_q.size() && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL beat_data[%0d]: got %0h want %0h", b, obs_q[b], exp_q[b]); end
      checks++;
      if (obs_ch_q[b] !== exp_ch) begin errors++; $display("FAIL beat_chan[%0d]: got %0d want %0d", b, obs_ch_q[b], exp_ch); end
      checks++;
      if (obs_cyc_q[b] !== exp_cyc_q[b]) begin errors++; $display("FAIL beat_latency[%0d]: got cyc %0d want %0d", b, obs_cyc_q[b], exp_cyc_q[b]); end
    end
    checks++;
    if (fin_beats !== n_fwd) begin errors++; $display("FAIL finish_order: beats before finish %0d want %0d", fin_beats, n_fwd); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ddr_rst_i = 1'b1;
    repeat (2) @(negedge ddr_clk_i);
    checks++; if (rd_ddr_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", rd_ddr_req); end
    checks++; if (rd_ddr_len !== 8'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", rd_ddr_len); end
    checks++; if (rd_ddr_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", rd_ddr_addr); end
    checks++; if ({ch0_valid, ch1_valid, ch0_fin, ch1_fin, rd_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {ch0_valid, ch1_valid, ch0_fin, ch1_fin, rd_timeout});
    end
    checks++; if (ch0_data !== '0 || ch1_data !== '0) begin errors++; $display("FAIL reset_data: got %0h/%0h want 0", ch0_data, ch1_data); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    ddr_rst_i = 1'b0;
    model_last = 1;
  endtask

  task automatic test_single();
    int r0;
    set_ch(0, 1'b1, 8'd4, AW'(32'h100));
    set_ch(1, 1'b0, 8'd0, '0);
    r0 = req_hi_cnt;
    check_burst(0, 4, 1'b0, 1'b0);
    ch_req[0] = 1'b0;
    checks++;
    if (req_hi_cnt - r0 !== 1) begin errors++; $display("FAIL req_width: got %0d cycles want 1", req_hi_cnt - r0); end
  endtask

  task automatic test_round_robin();
    int pick;
    do_reset();
    set_ch(0, 1'b1, 8'd2, AW'($urandom));
    set_ch(1, 1'b1, 8'd2, AW'($urandom));
    for (int i = 0; i < 4; i++) begin
      pick = model_pick();
      check_burst(pick, 2, 1'b0, 1'b1);
    end
  endtask

  task automatic test_len_zero();
    int rc;
    set_ch(1, 1'b1, 8'd0, AW'($urandom));
    set_ch(0, 1'b1, 8'd1, AW'($urandom));
    check_burst(0, 1, 1'b0, 1'b0);
    ch_req[0] = 1'b0;
    rc = req_rise_cnt;
    repeat (30) @(negedge ddr_clk_i);
    checks++;
    if (req_rise_cnt !== rc || rd_ddr_req !== 1'b0) begin
      errors++; $display("FAIL len_zero_grant: got %0d commands want 0", req_rise_cnt - rc);
    end
    ch_req[1] = 1'b0;
  endtask

  task automatic test_overrun();
    set_ch(0, 1'b1, 8'd2, AW'($urandom));
    set_ch(1, 1'b0, 8'd0, '0);
    check_burst(0, 3, 1'b0, 1'b0);
    ch_req[0] = 1'b0;
  endtask

  task automatic test_timeout();
    logic [AW-1:0] g_addr;
    logic [7:0] g_len;
    bit seen;
    int f0, f1, t0, waited, dt;
    set_ch(0, 1'b0, 8'd0, '0);
    set_ch(1, 1'b1, 8'd3, AW'($urandom));
    f0 = fin_cnt[0]; f1 = fin_cnt[1]; t0 = to_cnt;
    model_last = 1;
    serve_burst(1, 1, 1'b0, 1'b0, 1'b0, seen, g_addr, g_len);
    waited = 0;
    while (rd_timeout !== 1'b1 && waited < TO + 40) begin @(negedge ddr_clk_i); waited++; end
    dt = cyc - req_rise_cyc;
    checks++;
    if (rd_timeout !== 1'b1) begin errors++; $display("FAIL timeout_seen: got no rd_timeout want pulse"); end
    checks++;
    if (dt !== TO) begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", dt, TO); end
    @(negedge ddr_clk_i);
    ch_req[1] = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL timeout_state: got %0d want %0d", dbg_state, ST_IDLE); end
    checks++;
    if (rd_ddr_req !== 1'b0) begin errors++; $display("FAIL timeout_req: got %b want 0", rd_ddr_req); end
    repeat (6) @(negedge ddr_clk_i);
    checks++;
    if (to_cnt - t0 !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", to_cnt - t0); end
    checks++;
    if (fin_cnt[0] !== f0 || fin_cnt[1] !== f1) begin
      errors++; $display("FAIL timeout_finish: got %0d finishes want 0", fin_cnt[0] + fin_cnt[1] - f0 - f1);
    end
    set_ch(0, 1'b1, 8'd3, AW'($urandom));
    check_burst(0, 3, 1'b0, 1'b0);
    ch_req[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited, f0;
    set_ch(0, 1'b1, 8'd4, AW'($urandom));
    set_ch(1, 1'b0, 8'd0, '0);
    f0 = fin_cnt[0];
    waited = 0;
    while (rd_ddr_req !== 1'b1 && waited < 200) begin @(negedge ddr_clk_i); waited++; end
    for (int b = 0; b < 2; b++) begin
      rd_ddr_data_valid = 1'b1; rd_ddr_data = {$urandom, $urandom};
      @(negedge ddr_clk_i);
    end
    rd_ddr_data_valid = 1'b0;
    #2 ddr_rst_i = 1'b1;
    #1;
    checks++;
    if ({rd_ddr_req, ch0_valid, ch1_valid, ch0_fin, ch1_fin, rd_timeout} !== 6'b0) begin
      errors++; $display("FAIL midrst_strobes: got %b want 000000", {rd_ddr_req, ch0_valid, ch1_valid, ch0_fin, ch1_fin, rd_timeout});
    end
    checks++;
    if (rd_ddr_len !== 8'd0 || rd_ddr_addr !== '0 || ch0_data !== '0) begin
      errors++; $display("FAIL midrst_regs: got len %0d addr %0h data %0h want 0", rd_ddr_len, rd_ddr_addr, ch0_data);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge ddr_clk_i);
    @(negedge ddr_clk_i);
    ddr_rst_i = 1'b0;
    model_last = 1;
    checks++;
    if (fin_cnt[0] !== f0) begin errors++; $display("FAIL midrst_finish: got %0d want 0", fin_cnt[0] - f0); end
    set_ch(0, 1'b1, 8'($urandom_range(1, 4)), AW'($urandom));
    set_ch(1, 1'b1, 8'($urandom_range(1, 4)), AW'($urandom));
    check_burst(model_pick(), 4, 1'b0, 1'b0);
    set_ch(0, 1'b0, 8'd0, '0);
    set_ch(1, 1'b0, 8'd0, '0);
  endtask

  task automatic test_random();
    int pick, rc, nb;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < 2; c++) set_ch(c, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 6)), AW'($urandom));
      pick = model_pick();
      if (pick < 0) begin
        rc = req_rise_cnt;
        repeat (12) @(negedge ddr_clk_i);
        checks++;
        if (req_rise_cnt !== rc) begin errors++; $display("FAIL idle_grant: got %0d commands want 0", req_rise_cnt - rc); end
      end else begin
        nb = $urandom_range(1, int'(ch_len[pick]) + 2);
        check_burst(pick, nb, 1'($urandom_range(0, 1)), 1'b1);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 2; c++) set_ch(c, 1'b0, 8'd0, '0);
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge ddr_clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
